sdpram_fifo_ctrl: RTL and testbench

//   Synchronous FIFO controller placed directly upstream of the simple dual-port RAM (16b x 256).

---
 rtl/sdpram_pkg.sv | 21 ++
 rtl/fifo_out_skid.sv | 64 ++++++
 rtl/sdpram_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_sdpram_fifo_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdpram_pkg
//  Purpose  : Shared widths and types for the 16b x 256 simple dual-port RAM
//             and the FIFO controller that sits upstream of it.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sdpram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  // Pointers carry one extra bit so full and empty are distinguishable.
  typedef logic [ADDR_W_DEF:0]   ptr_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage
`default_nettype wire

// File: rtl/fifo_out_skid.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_out_skid
//  Purpose  : Two-entry output buffer that absorbs the RAM read latency so the
//             read stream can run at one word per cycle.
//  Ports    : clk, rst_n      - clock, synchronous active-low reset
//             push/push_data  - word returning from the RAM
//             pop             - consumer takes the head word
//             out_cnt         - entries held (0..2)
//             head_data       - oldest entry
//  Revision : 1.0  initial release
// ============================================================================
module fifo_out_skid
  import sdpram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        out_cnt,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] r_ent0;  // head
  logic [DATA_W-1:0] r_ent1;
  logic [1:0]        r_cnt;

  // The issuing side never pushes into a full buffer without a pop in the same
  // cycle, and pop is only asserted while r_cnt is non-zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ent0 <= push_data;
          else               r_ent1 <= push_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_ent0 <= r_ent1;
            r_ent1 <= push_data;
          end else begin
            r_ent0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_cnt   = r_cnt;
  assign head_data = r_ent0;

endmodule
`default_nettype wire

// File: rtl/sdpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sdpram_fifo_ctrl
//  Purpose  : Synchronous FIFO controller for an external simple dual-port
//             RAM. Converts a valid/ready write stream into RAM port-A writes,
//             issues port-B reads and re-times the one-cycle read data into a
//             valid/ready output stream.
//  Ports    : clk, rst_n                - clock, synchronous active-low reset
//             s_valid/s_ready/s_data    - write stream
//             m_valid/m_ready/m_data    - read stream
//             count/full/empty          - occupancy status
//             ram_wea/addra/data_a      - RAM port A (write)
//             ram_enb/addrb/data_b      - RAM port B (read, 1-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module sdpram_fifo_ctrl
  import sdpram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_data_b
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_ptr_depth = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_rd_inflight;

  logic [ADDR_W:0] w_ram_cnt;
  logic            w_ram_full;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;
  logic [1:0]      w_out_cnt;
  logic [2:0]      w_pending;

  // Words written at earlier edges that have not yet been read out of the RAM.
  assign w_ram_cnt  = r_wr_ptr - r_rd_ptr;
  assign w_ram_full = (w_ram_cnt == c_ptr_depth);

  // Registered-state only: a pop in this cycle does not open a slot until the
  // following cycle.
  assign s_ready = rst_n && !w_ram_full;
  assign w_push  = s_valid && s_ready;

  assign m_valid = (w_out_cnt != 2'd0);
  assign w_pop   = m_valid && m_ready;

  // Buffer slots already spoken for after this cycle's pop; a new read is only
  // issued if its data is guaranteed a slot when it returns. w_pop implies
  // w_out_cnt >= 1, so the subtraction cannot underflow.
  assign w_pending = {1'b0, w_out_cnt} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
  assign w_issue   = rst_n && (w_ram_cnt != '0) && (w_pending < 3'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rd_inflight <= w_issue;
    end
  end

  assign ram_wea    = w_push;
  assign ram_addra  = r_wr_ptr[ADDR_W-1:0];
  assign ram_data_a = s_data;
  assign ram_enb    = w_issue;
  assign ram_addrb  = r_rd_ptr[ADDR_W-1:0];

  // Read data is only captured when a read was issued last cycle; clearing
  // r_rd_inflight in reset therefore drops any read still in the RAM pipeline.
  fifo_out_skid #(
    .DATA_W (DATA_W)
  ) u_out_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_rd_inflight),
    .push_data (ram_data_b),
    .pop       (w_pop),
    .out_cnt   (w_out_cnt),
    .head_data (m_data)
  );

  assign count = {1'b0, w_ram_cnt}
               + {{(ADDR_W+1){1'b0}}, r_rd_inflight}
               + {{ADDR_W{1'b0}}, w_out_cnt};
  assign full  = w_ram_full;
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: tb/tb_sdpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdpram_fifo_ctrl
//  Purpose  : Self-checking bench for sdpram_fifo_ctrl together with a
//             behavioural 16b x 256 simple dual-port RAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdpram_fifo_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [AW+1:0] count;
  logic          full, empty;
  logic          ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_data_a, ram_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdpram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ram_wea    (ram_wea),
    .ram_addra  (ram_addra),
    .ram_data_a (ram_data_a),
    .ram_enb    (ram_enb),
    .ram_addrb  (ram_addrb),
    .ram_data_b (ram_data_b)
  );

  // Behavioural RAM: registered read, one cycle latency.
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_wea) ram_mem[ram_addra] <= ram_data_a;
    if (ram_enb) ram_data_b <= ram_mem[ram_addrb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the FIFO is a queue of words tagged with their accept
  // cycle. Occupancy, order, visibility deadline and address sequences are
  // derived from that queue and from running write/read counts.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } ent_t;

  ent_t          q[$];
  int            cyc_n     = 0;
  int            wr_n      = 0;
  int            rd_n      = 0;
  bit            model_on  = 0;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_wea", ram_wea, 0);
      chk("rst_enb", ram_enb, 0);
      q.delete();
      wr_n      = 0;
      rd_n      = 0;
      prev_hold = 0;
      model_on  = 1;
    end else if (model_on) begin
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full_vs_ready", full, !s_ready);
      if (q.size() < DEPTH)     chk("ready_low_occ", s_ready, 1);
      if (q.size() == DEPTH + 2) chk("ready_at_cap", s_ready, 0);
      if (q.size() == 0) chk("mvalid_empty", m_valid, 0);
      else if (q[0].c + 3 <= cyc_n) chk("mvalid_deadline", m_valid, 1);
      if (m_valid === 1'b1 && q.size() > 0) chk("m_data_order", m_data, q[0].d);
      if (prev_hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      chk("wea", ram_wea, s_valid && s_ready);
      if (ram_wea === 1'b1) begin
        chk("addra_seq", ram_addra, wr_n % DEPTH);
        chk("data_a", ram_data_a, s_data);
      end
      if (ram_enb === 1'b1) begin
        chk("addrb_seq", ram_addrb, rd_n % DEPTH);
        chk("read_after_write", rd_n < wr_n, 1);
        rd_n++;
      end
      if (m_valid === 1'b1 && m_ready && q.size() > 0) void'(q.pop_front());
      if (ram_wea === 1'b1) begin
        q.push_back('{d: s_data, c: cyc_n});
        wr_n++;
      end
      prev_hold = (m_valid === 1'b1) && !m_ready;
      prev_data = m_data;
    end
    cyc_n++;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_w, got, first, bub, sent, popped, found;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    do_reset();

    // ---- 1: single word latency ----
    @(negedge clk);
    chk("t1_reset_mvalid", m_valid, 0);
    chk("t1_reset_count", count, 0);
    chk("t1_reset_empty", empty, 1);
    chk("t1_reset_full", full, 0);
    cyc();
    s_valid = 1; s_data = 16'h1234; m_ready = 1;
    @(negedge clk);
    chk("t1_accept", s_ready, 1);
    chk("t1_addra", ram_addra, 0);
    cyc();
    s_valid = 0;
    @(negedge clk);
    chk("t1_c1_count", count, 1);
    chk("t1_c1_mvalid", m_valid, 0);
    cyc();
    @(negedge clk);
    chk("t1_c2_mvalid", m_valid, 0);
    cyc();
    @(negedge clk);
    chk("t1_c3_mvalid", m_valid, 1);
    chk("t1_c3_data", m_data, 16'h1234);
    chk("t1_c3_count", count, 1);
    cyc();
    @(negedge clk);
    chk("t1_c4_count", count, 0);
    chk("t1_c4_empty", empty, 1);
    cyc();

    // ---- 2 and 6: fill to capacity, pop at full, then drain ----
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      s_valid = 1; s_data = 16'(i);
      @(negedge clk);
      chk("t2_fill_accept", s_ready, 1);
      cyc();
    end
    s_valid = 1; s_data = 16'h0102; m_ready = 1;
    @(negedge clk);
    chk("t2_full_ready", s_ready, 0);
    chk("t2_full_flag", full, 1);
    chk("t2_full_count", count, 258);
    chk("t6_no_write_at_full", ram_wea, 0);
    chk("t6_head", m_data, 16'h0000);
    cyc();
    m_ready = 0;
    @(negedge clk);
    chk("t6_accept_next", s_ready, 1);
    chk("t6_write_next", ram_wea, 1);
    cyc();
    s_valid = 0;
    @(negedge clk);
    chk("t6_count_back", count, 258);
    cyc();
    m_ready = 1;
    exp_w = 1;
    for (int c = 0; c < 1000 && exp_w < 16'h0103; c++) begin
      @(negedge clk);
      if (m_valid) begin
        chk("t2_drain_data", m_data, exp_w);
        exp_w++;
      end
      cyc();
    end
    chk("t2_drained_all", exp_w, 32'h0103);
    @(negedge clk);
    chk("t2_empty_after", empty, 1);
    cyc();

    // ---- 3: streaming throughput ----
    do_reset();
    m_ready = 1; got = 0; first = -1; bub = 0; sent = 0;
    for (int c = 0; c < 1200 && got < 1000; c++) begin
      s_valid = (sent < 1000);
      s_data  = 16'(16'h4000 + sent);
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      if (m_valid) begin
        chk("t3_data", m_data, 16'h4000 + got);
        if (first < 0) first = c;
        got++;
      end else if (first >= 0) begin
        bub++;
      end
      cyc();
    end
    s_valid = 0;
    chk("t3_first_latency", first, 3);
    chk("t3_bubbles", bub, 0);
    chk("t3_words", got, 1000);

    // ---- 4: random handshakes ----
    do_reset();
    sent = 0; popped = 0;
    for (int c = 0; c < 40000 && popped < 5000; c++) begin
      s_valid = (sent < 5000) && ($urandom_range(0, 1) == 1);
      s_data  = 16'($urandom);
      m_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) popped++;
      cyc();
    end
    s_valid = 0; m_ready = 0;
    chk("t4_popped", popped, 5000);

    // ---- 5: reset with a read in flight ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = 16'(16'hA000 + i);
      @(negedge clk);
      chk("t5_fill_accept", s_ready, 1);
      cyc();
    end
    s_valid = 0;
    repeat (4) cyc();
    s_valid = 1; s_data = 16'hA005; m_ready = 1;
    @(negedge clk);
    chk("t5_push_pop_wea", ram_wea, 1);
    chk("t5_push_pop_mvalid", m_valid, 1);
    cyc();
    s_valid = 0; m_ready = 0; rst_n = 0;
    @(negedge clk);
    chk("t5_count_pre", count, 5);
    cyc();
    rst_n = 1;
    @(negedge clk);
    chk("t5_mvalid_post", m_valid, 0);
    chk("t5_count_post", count, 0);
    chk("t5_empty_post", empty, 1);
    cyc();
    s_valid = 1; s_data = 16'hBEEF;
    @(negedge clk);
    chk("t5_beef_wea", ram_wea, 1);
    chk("t5_beef_addra", ram_addra, 0);
    cyc();
    s_valid = 0; m_ready = 1; found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (m_valid) begin
        chk("t5_beef_data", m_data, 16'hBEEF);
        found = 1;
      end
      cyc();
    end
    chk("t5_beef_seen", found, 1);
    m_ready = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
